pio_loader: RTL and testbench

PIO_LOADER -- requirements
Module: pio_loader

---
 rtl/pio_loader.sv | 153 +++++++++++++++
 tb/tb_pio_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_loader.sv
`default_nettype none
// ============================================================================
//  Module      : pio_loader
//  Description : Boot-time loader and stream front end for a PIO block.
//                Copies PROG_LEN instruction words from a program ROM onto
//                the PIO command bus, then applies CONF_LEN configuration
//                entries from a config ROM, then forwards stream words as
//                TX FIFO pushes. A load pulse in RUN restarts the sequence.
//
//  Ports       : clk_25mhz, reset   - clock, synchronous active-high reset
//                load               - reload request pulse (honoured in RUN)
//                prog_addr/prog_data- program ROM, 1-cycle read latency
//                conf_addr/conf_data- config ROM {mindex,action,data},
//                                     1-cycle read latency
//                stream_*           - valid/ready stream of 32-bit words
//                full               - per-machine TX FIFO full flags
//                din/index/action/mindex - registered PIO command bus
//                busy, done         - loading in progress / running
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_loader #(
    parameter int         PROG_LEN = 32,
    parameter int         CONF_LEN = 4,
    parameter logic [3:0] PUSH_ACT = 4'd4
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic        load,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [4:0]  conf_addr,
    input  logic [37:0] conf_data,
    input  logic        stream_valid,
    input  logic [31:0] stream_data,
    input  logic [1:0]  stream_mach,
    output logic        stream_ready,
    input  logic [3:0]  full,
    output logic [31:0] din,
    output logic [4:0]  index,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_PROG = 2'd0,
        ST_CONF = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Counter limits. The counter runs one past the last address so the
    // final ROM word (returned a cycle after its address) is still written,
    // and one more so the phase ends the cycle after that last write.
    localparam logic [5:0] c_prog_len = 6'(PROG_LEN);
    localparam logic [5:0] c_prog_end = 6'(PROG_LEN + 1);
    localparam logic [5:0] c_conf_len = 6'(CONF_LEN);
    localparam logic [5:0] c_conf_end = 6'(CONF_LEN + 1);

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [3:0]  r_action;
    logic [31:0] r_din;
    logic [4:0]  r_index;
    logic [1:0]  r_mindex;

    logic        w_accept;

    // Counter doubles as ROM address; only the phase's own ROM is consumed.
    assign prog_addr    = r_cnt[4:0];
    assign conf_addr    = r_cnt[4:0];

    // A reload request masks ready so the word is left for after the reload.
    assign stream_ready = (r_state == ST_RUN) & ~full[stream_mach] & ~load;
    assign w_accept     = stream_valid & stream_ready;

    assign action       = r_action;
    assign din          = r_din;
    assign index        = r_index;
    assign mindex       = r_mindex;
    assign busy         = (r_state != ST_RUN);
    assign done         = (r_state == ST_RUN);

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state  <= ST_PROG;
            r_cnt    <= 6'd0;
            r_action <= 4'd0;
            r_din    <= 32'd0;
            r_index  <= 5'd0;
            r_mindex <= 2'd0;
        end else begin
            // Command bus is idle unless a write or push is issued below;
            // the data fields keep their last value.
            r_action <= 4'd0;

            case (r_state)
                ST_PROG: begin
                    // prog_data now holds the word for address r_cnt-1.
                    if ((r_cnt != 6'd0) && (r_cnt <= c_prog_len)) begin
                        r_action <= 4'd1;
                        r_index  <= r_cnt[4:0] - 5'd1;
                        r_din    <= {16'h0000, prog_data};
                        r_mindex <= 2'd0;
                    end
                    if (r_cnt == c_prog_end) begin
                        r_cnt   <= 6'd0;
                        r_state <= (CONF_LEN == 0) ? ST_RUN : ST_CONF;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end

                ST_CONF: begin
                    // Entries with a zero action go out as action 0: the
                    // slot is spent but nothing is written.
                    if ((r_cnt != 6'd0) && (r_cnt <= c_conf_len)) begin
                        r_action <= conf_data[35:32];
                        r_index  <= 5'd0;
                        r_din    <= conf_data[31:0];
                        r_mindex <= conf_data[37:36];
                    end
                    if (r_cnt == c_conf_end) begin
                        r_cnt   <= 6'd0;
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_action <= PUSH_ACT;
                        r_din    <= stream_data;
                        r_mindex <= stream_mach;
                    end
                    if (load) begin
                        r_state <= ST_PROG;
                        r_cnt   <= 6'd0;
                    end
                end

                default: begin
                    r_state <= ST_PROG;
                    r_cnt   <= 6'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pio_loader
//  Description : Self-checking bench for pio_loader. Main instance uses
//                PROG_LEN=32/CONF_LEN=4; a second instance uses CONF_LEN=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_loader;

    localparam int PROG_LEN   = 32;
    localparam int CONF_LEN   = 4;
    localparam int PROG_LEN_B = 16;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  act;
        logic [4:0]  idx;
        logic [31:0] dat;
        logic [1:0]  mi;
    } wr_t;

    logic clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    // main instance signals
    logic        reset = 1'b1, load = 1'b0;
    logic [4:0]  prog_addr, conf_addr, index;
    logic [15:0] prog_data;
    logic [37:0] conf_data;
    logic        stream_valid = 1'b0;
    logic [31:0] stream_data = 32'd0;
    logic [1:0]  stream_mach = 2'd0;
    logic        stream_ready;
    logic [3:0]  full = 4'd0;
    logic [31:0] din;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic        busy, done;

    // second instance signals
    logic        reset_b = 1'b1, load_b = 1'b0;
    logic [4:0]  prog_addr_b, conf_addr_b, index_b;
    logic [15:0] prog_data_b;
    logic [37:0] conf_data_b = 38'd0;
    logic        stream_valid_b = 1'b0;
    logic [31:0] stream_data_b = 32'd0;
    logic [1:0]  stream_mach_b = 2'd0;
    logic        stream_ready_b;
    logic [3:0]  full_b = 4'd0;
    logic [31:0] din_b;
    logic [3:0]  action_b;
    logic [1:0]  mindex_b;
    logic        busy_b, done_b;

    pio_loader #(.PROG_LEN(PROG_LEN), .CONF_LEN(CONF_LEN), .PUSH_ACT(4'd4)) dut (
        .clk_25mhz(clk_25mhz), .reset(reset), .load(load),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .conf_addr(conf_addr), .conf_data(conf_data),
        .stream_valid(stream_valid), .stream_data(stream_data),
        .stream_mach(stream_mach), .stream_ready(stream_ready), .full(full),
        .din(din), .index(index), .action(action), .mindex(mindex),
        .busy(busy), .done(done)
    );

    pio_loader #(.PROG_LEN(PROG_LEN_B), .CONF_LEN(0), .PUSH_ACT(4'd4)) dut_b (
        .clk_25mhz(clk_25mhz), .reset(reset_b), .load(load_b),
        .prog_addr(prog_addr_b), .prog_data(prog_data_b),
        .conf_addr(conf_addr_b), .conf_data(conf_data_b),
        .stream_valid(stream_valid_b), .stream_data(stream_data_b),
        .stream_mach(stream_mach_b), .stream_ready(stream_ready_b), .full(full_b),
        .din(din_b), .index(index_b), .action(action_b), .mindex(mindex_b),
        .busy(busy_b), .done(done_b)
    );

    // ROM models with one cycle of read latency
    logic [37:0] conf_rom [0:31];
    always @(posedge clk_25mhz) begin
        prog_data   <= 16'hA000 + {11'd0, prog_addr};
        conf_data   <= conf_rom[conf_addr];
        prog_data_b <= 16'hB000 + {11'd0, prog_addr_b};
    end

    int unsigned cyc = 0;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    wr_t exp_q[$], obs_q[$], exp_b_q[$], obs_b_q[$];

    // record every non-idle command bus cycle
    always @(negedge clk_25mhz) begin
        if (action !== 4'd0)
            obs_q.push_back(wr_t'{cyc: cyc, act: action, idx: index, dat: din, mi: mindex});
        if (action_b !== 4'd0)
            obs_b_q.push_back(wr_t'{cyc: cyc, act: action_b, idx: index_b, dat: din_b, mi: mindex_b});
    end

    int checks = 0;
    int errors = 0;
    int unsigned base;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    task automatic settle();
        @(negedge clk_25mhz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++; if (action !== 4'd0)        begin errors++; $display("FAIL rst_action: got %0d expected 0", action); end
        checks++; if (din !== 32'd0)          begin errors++; $display("FAIL rst_din: got %h expected 0", din); end
        checks++; if (index !== 5'd0)         begin errors++; $display("FAIL rst_index: got %0d expected 0", index); end
        checks++; if (mindex !== 2'd0)        begin errors++; $display("FAIL rst_mindex: got %0d expected 0", mindex); end
        checks++; if (prog_addr !== 5'd0)     begin errors++; $display("FAIL rst_prog_addr: got %0d expected 0", prog_addr); end
        checks++; if (conf_addr !== 5'd0)     begin errors++; $display("FAIL rst_conf_addr: got %0d expected 0", conf_addr); end
        checks++; if (stream_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %b expected 0", stream_ready); end
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL rst_busy: got %b expected 1", busy); end
        obs_q.delete();
    endtask

    task automatic test_conf_len0();
        wr_t e, o;
        obs_b_q.delete();
        base = cyc;
        reset_b = 1'b0;
        for (int i = 0; i <= 10; i++)
            exp_b_q.push_back(wr_t'{cyc: base + 2 + i, act: 4'd1, idx: 5'(i), dat: 32'h0000B000 + 32'(i), mi: 2'd0});
        step(12);
        checks++; if (index_b !== 5'd10) begin errors++; $display("FAIL b_at_instr10: got index %0d expected 10", index_b); end
        reset_b = 1'b1;
        step(1);
        checks++; if (action_b !== 4'd0 || busy_b !== 1'b1) begin errors++; $display("FAIL b_reset_abort: got action %0d busy %b expected 0/1", action_b, busy_b); end
        step(1);
        base = cyc;
        reset_b = 1'b0;
        for (int i = 0; i < PROG_LEN_B; i++)
            exp_b_q.push_back(wr_t'{cyc: base + 2 + i, act: 4'd1, idx: 5'(i), dat: 32'h0000B000 + 32'(i), mi: 2'd0});
        step(PROG_LEN_B + 1);
        checks++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin errors++; $display("FAIL b_last_write_state: got done %b busy %b expected 0/1", done_b, busy_b); end
        step(1);
        checks++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin errors++; $display("FAIL b_run_entry: got done %b busy %b expected 1/0", done_b, busy_b); end
        settle();
        while (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            checks++;
            if (obs_b_q.size() == 0) begin
                errors++; $display("FAIL b_write: got none, expected cyc %0d idx %0d din %h", e.cyc, e.idx, e.dat);
            end else begin
                o = obs_b_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b_write: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_b_q.size() != 0) begin errors++; $display("FAIL b_extra: got %0d extra writes expected 0", obs_b_q.size()); obs_b_q.delete(); end
    endtask

    task automatic test_prog();
        wr_t e, o;
        obs_q.delete();
        base = cyc;
        reset = 1'b0;
        for (int i = 0; i < PROG_LEN; i++)
            exp_q.push_back(wr_t'{cyc: base + 2 + i, act: 4'd1, idx: 5'(i), dat: 32'h0000A000 + 32'(i), mi: 2'd0});
        step(PROG_LEN + 1);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL prog_busy: got busy %b done %b expected 1/0", busy, done); end
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL prog_write: got none, expected cyc %0d idx %0d din %h", e.cyc, e.idx, e.dat);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL prog_write: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL prog_extra: got %0d extra writes expected 0", obs_q.size()); obs_q.delete(); end
        step(1);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL conf_entry: got busy %b done %b expected 1/0", busy, done); end
    endtask

    // continues directly from test_prog (CONF counter at 0 on entry)
    task automatic test_conf();
        wr_t e, o;
        logic [3:0] acts [4];
        acts[0] = 4'd1; acts[1] = 4'd0; acts[2] = 4'd3; acts[3] = 4'd5;
        for (int k = 0; k < CONF_LEN; k++)
            if (acts[k] != 4'd0)
                exp_q.push_back(wr_t'{cyc: base + 36 + k, act: acts[k], idx: 5'd0,
                                      dat: 32'h10 * 32'(k + 1), mi: 2'(k)});
        load = 1'b1;   // must be ignored in CONF
        step(1);
        load = 1'b0;
        step(2);
        checks++; if (action !== 4'd0 || mindex !== 2'd1 || din !== 32'h20)
            begin errors++; $display("FAIL conf_skip: got act %0d mi %0d din %h expected 0/1/00000020", action, mindex, din); end
        step(2);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL conf_done_early: got %b expected 0", done); end
        step(1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL run_entry: got done %b busy %b expected 1/0", done, busy); end
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL conf_write: got none, expected cyc %0d act %0d", e.cyc, e.act);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL conf_write: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL conf_extra: got %0d extra writes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_full();
        wr_t e, o;
        full = 4'b0010; stream_mach = 2'd1; stream_data = 32'hCAFE0001; stream_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL full_block_ready: got %b expected 0", stream_ready); end
            step(1);
        end
        full = 4'b0000;
        #1;
        checks++; if (stream_ready !== 1'b1) begin errors++; $display("FAIL full_clear_ready: got %b expected 1", stream_ready); end
        exp_q.push_back(wr_t'{cyc: cyc + 1, act: 4'd4, idx: 5'd0, dat: 32'hCAFE0001, mi: 2'd1});
        step(1);
        stream_valid = 1'b0;
        step(1);
        // full on machine 1 must not block machine 0
        full = 4'b0010; stream_mach = 2'd0; stream_data = 32'h00000055; stream_valid = 1'b1;
        #1;
        checks++; if (stream_ready !== 1'b1) begin errors++; $display("FAIL other_mach_ready: got %b expected 1", stream_ready); end
        exp_q.push_back(wr_t'{cyc: cyc + 1, act: 4'd4, idx: 5'd0, dat: 32'h00000055, mi: 2'd0});
        step(1);
        stream_valid = 1'b0; full = 4'b0000;
        step(2);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL full_push: got none, expected cyc %0d din %h", e.cyc, e.dat);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL full_push: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL full_extra: got %0d extra pushes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        wr_t e, o;
        full = 4'b0000; stream_mach = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            stream_data = 32'(k); stream_valid = 1'b1;
            #1;
            checks++; if (stream_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", stream_ready); end
            exp_q.push_back(wr_t'{cyc: cyc + 1, act: 4'd4, idx: 5'd0, dat: 32'(k), mi: 2'd0});
            step(1);
        end
        stream_valid = 1'b0;
        step(2);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_push: got none, expected cyc %0d din %h", e.cyc, e.dat);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_push: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra: got %0d extra pushes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_load_run();
        wr_t e, o;
        stream_mach = 2'd0; stream_data = 32'h0000DEAD; stream_valid = 1'b1; load = 1'b1;
        #1;
        checks++; if (stream_ready !== 1'b0) begin errors++; $display("FAIL load_ready: got %b expected 0", stream_ready); end
        step(1);
        load = 1'b0; stream_valid = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0 || action !== 4'd0)
            begin errors++; $display("FAIL load_restart: got busy %b done %b act %0d expected 1/0/0", busy, done, action); end
        base = cyc;
        for (int i = 0; i < PROG_LEN; i++)
            exp_q.push_back(wr_t'{cyc: base + 2 + i, act: 4'd1, idx: 5'(i), dat: 32'h0000A000 + 32'(i), mi: 2'd0});
        step(PROG_LEN + 1);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reload_write: got none, expected cyc %0d idx %0d", e.cyc, e.idx);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL reload_write: got cyc %0d act %0d idx %0d din %h mi %0d, expected cyc %0d act %0d idx %0d din %h mi %0d",
                             o.cyc, o.act, o.idx, o.dat, o.mi, e.cyc, e.act, e.idx, e.dat, e.mi);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reload_extra: got %0d extra writes expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    // continues from test_load_run: reset in the middle of CONF
    task automatic test_reset_mid_conf();
        step(4);
        reset = 1'b1;
        step(1);
        checks++; if (action !== 4'd0 || din !== 32'd0 || mindex !== 2'd0 || conf_addr !== 5'd0)
            begin errors++; $display("FAIL midconf_reset: got act %0d din %h mi %0d caddr %0d expected all 0", action, din, mindex, conf_addr); end
        checks++; if (busy !== 1'b1 || done !== 1'b0 || stream_ready !== 1'b0)
            begin errors++; $display("FAIL midconf_reset_flags: got busy %b done %b ready %b expected 1/0/0", busy, done, stream_ready); end
        reset = 1'b0;
        step(2);
        checks++; if (action !== 4'd1 || index !== 5'd0 || din !== 32'h0000A000)
            begin errors++; $display("FAIL midconf_restart: got act %0d idx %0d din %h expected 1/0/0000a000", action, index, din); end
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) conf_rom[i] = 38'd0;
        conf_rom[0] = {2'd0, 4'd1, 32'h10};
        conf_rom[1] = {2'd1, 4'd0, 32'h20};
        conf_rom[2] = {2'd2, 4'd3, 32'h30};
        conf_rom[3] = {2'd3, 4'd5, 32'h40};

        test_reset();
        test_conf_len0();
        test_prog();
        test_conf();
        test_full();
        test_back_to_back();
        test_load_run();
        test_reset_mid_conf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no completion within time limit, expected summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
